data_mem_lsu: RTL and testbench

Parametrised, byte-addressed data memory for the RISC-V core's MEM stage. It executes RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) with byte-lane writes and sign/zero extension. It flags misaligned, out-of-range and illegal-size accesses. A valid/ready request channel feeds a registered, back-pressurable response channel, so one access can be issued per cycle.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/load_formatter.sv | 27 ++
 rtl/data_mem_lsu.sv | 135 +++++++++++++
 tb/tb_data_mem_lsu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store path: RV32I funct3
// size codes, access-size classification and the word width in bytes.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2,
    LS_BAD  = 2'd3
  } ls_size_t;

  // Classify a funct3 code into an access size; unsigned variants are
  // only meaningful for loads, so a store using them is illegal.
  function automatic ls_size_t decode_size(input logic we, input logic [2:0] funct3);
    ls_size_t size_v;
    case (funct3)
      F3_B:    size_v = LS_BYTE;
      F3_H:    size_v = LS_HALF;
      F3_W:    size_v = LS_WORD;
      F3_BU:   size_v = we ? LS_BAD : LS_BYTE;
      F3_HU:   size_v = we ? LS_BAD : LS_HALF;
      default: size_v = LS_BAD;
    endcase
    return size_v;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load aligner: moves the addressed byte/halfword of a
// memory word down to bit 0 and sign- or zero-extends it per funct3.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted_s;

  // Align the selected lane to bit 0 and apply the extension rule.
  always_comb begin
    shifted_s = word >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    rdata = word;
      F3_BU:   rdata = {24'h000000, shifted_s[7:0]};
      F3_HU:   rdata = {16'h0000, shifted_s[15:0]};
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory for the MEM stage. Requests are decoded for
// faults, stores update the byte lanes at the acceptance edge, and every
// accepted request produces one registered, back-pressurable response.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]   offset_s;
  logic [AW-1:0] word_idx_s;
  logic          range_ok_s;
  logic          misalign_s;
  logic          fault_s;
  ls_size_t      size_s;
  logic          accept_s;
  logic          wr_en_s;
  logic [3:0]    be_s;
  logic [31:0]   wr_lane_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   ld_data_s;

  logic          rsp_valid_r;
  logic [31:0]   rsp_rdata_r;
  logic          rsp_err_r;

  // A slot opens when the output register is empty or being drained.
  assign req_ready = !rsp_valid_r || rsp_ready;
  assign accept_s  = req_valid && req_ready;
  // Reset gating keeps a store presented during reset out of memory.
  assign wr_en_s   = accept_s && req_we && !fault_s && rst_n;

  // Fault decode: illegal size code, misalignment, or out-of-window address.
  always_comb begin
    offset_s   = req_addr - BASE_ADDR;
    word_idx_s = offset_s[AW+1:2];
    range_ok_s = ({1'b0, offset_s} < MEM_BYTES);
    size_s     = decode_size(req_we, req_funct3);
    case (size_s)
      LS_BYTE: misalign_s = 1'b0;
      LS_HALF: misalign_s = req_addr[0];
      LS_WORD: misalign_s = (req_addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
    fault_s = (size_s == LS_BAD) || misalign_s || !range_ok_s;
  end

  // Store lane steering: replicate the low data bits across lanes and
  // enable only the lanes covered by the access.
  always_comb begin
    be_s      = 4'b0000;
    wr_lane_s = req_wdata;
    case (size_s)
      LS_BYTE: begin
        be_s      = 4'b0001 << req_addr[1:0];
        wr_lane_s = {4{req_wdata[7:0]}};
      end
      LS_HALF: begin
        be_s      = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_lane_s = {2{req_wdata[15:0]}};
      end
      LS_WORD: begin
        be_s      = 4'b1111;
        wr_lane_s = req_wdata;
      end
      default: begin
        be_s      = 4'b0000;
        wr_lane_s = req_wdata;
      end
    endcase
  end

  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    logic [7:0] lane_mem_r [DEPTH_WORDS];

    // Byte lane storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (wr_en_s && be_s[i]) begin
        lane_mem_r[word_idx_s] <= wr_lane_s[8*i +: 8];
      end
    end

    assign rd_word_s[8*i +: 8] = lane_mem_r[word_idx_s];
  end

  load_formatter u_fmt (
    .word    (rd_word_s),
    .addr_lo (req_addr[1:0]),
    .funct3  (req_funct3),
    .rdata   (ld_data_s)
  );

  // Response register: load on accept, clear when drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= fault_s;
      rsp_rdata_r <= (fault_s || req_we) ? 32'h0000_0000 : ld_data_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
      rsp_rdata_r <= rsp_rdata_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed test-plan steps followed
// by a randomized phase, all checked against a byte-array reference model
// and a queue of expected responses.
module tb_data_mem_lsu;
  import mem_pkg::*;

  localparam int          DEPTH  = 64;
  localparam int          NBYTES = DEPTH * 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [7:0]  mdl [NBYTES];
  int          total = 0;
  int          bad = 0;
  logic [31:0] s_rdata;
  logic        s_err, s_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference behaviour from the access rules, on a plain byte array.
  function automatic rsp_t model_exec(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd);
    rsp_t   r;
    int     n;
    bit     legal;
    longint v;
    longint lim;
    n     = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    r.rd  = 32'd0;
    r.err = 1'b0;
    if (!legal || (longint'(a) % n != 0) || (longint'(a) - longint'(BASE) >= NBYTES)
        || (longint'(a) < longint'(BASE))) begin
      r.err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < n; i++) mdl[int'(a - BASE) + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(mdl[int'(a - BASE) + i]) << (8 * i);
      lim = longint'(1) << (8 * n - 1);
      if (f3 < 3'd4 && n < 4 && v >= lim) v -= 2 * lim;
      r.rd = v[31:0];
    end
    return r;
  endfunction

  // One clock cycle: drive inputs, sample at the falling edge, check
  // against the model, then advance to just after the next rising edge.
  task automatic step(input logic v, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic rr, output logic acc);
    logic pend;
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = rr;
    #4;
    pend    = (exp_q.size() != 0);
    s_valid = rsp_valid; s_rdata = rsp_rdata; s_err = rsp_err;
    chk("rsp_valid", 32'(rsp_valid), 32'(pend));
    chk("req_ready", 32'(req_ready), 32'(pend ? rr : 1'b1));
    if (pend) begin
      chk("rsp_rdata", rsp_rdata, exp_q[0].rd);
      chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
      if (rr) void'(exp_q.pop_front());
    end else begin
      chk("idle_rdata", rsp_rdata, 32'd0);
      chk("idle_err", 32'(rsp_err), 32'd0);
    end
    acc = v && (!pend || rr);
    if (acc) exp_q.push_back(model_exec(we, f3, a, wd));
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int tries);
    logic acc;
    tries = 0;
    do begin
      step(1'b1, we, f3, a, wd, 1'b1, acc);
      tries++;
    end while (!acc && tries < 20);
    chk("accept_bound", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      step(1'b0, 1'b0, F3_W, 32'd0, 32'd0, 1'b1, acc);
    chk("drain_bound", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic op_then_check(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_err);
    logic acc;
    int   tries;
    issue(we, f3, a, wd, tries);
    step(1'b0, 1'b0, F3_W, 32'd0, 32'd0, 1'b1, acc);
    chk({tag, "_valid"}, 32'(s_valid), 32'd1);
    chk(tag, s_rdata, exp_rd);
    chk({tag, "_err"}, 32'(s_err), 32'(exp_err));
  endtask

  initial begin
    logic        acc;
    int          tries;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int          n;
    logic [2:0]  bp_f3 [4];
    logic [31:0] bp_a  [4];

    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word and byte/half lanes
    op_then_check("sw_10",    1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    op_then_check("lw_10",    1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    op_then_check("sb_12",    1'b1, F3_B,  32'h12, 32'h123456A5, 32'h0, 1'b0);
    op_then_check("lw_10_sb", 1'b0, F3_W,  32'h10, 32'h0, 32'hDEA5BEEF, 1'b0);
    op_then_check("lb_12",    1'b0, F3_B,  32'h12, 32'h0, 32'hFFFFFFA5, 1'b0);
    op_then_check("lbu_12",   1'b0, F3_BU, 32'h12, 32'h0, 32'h000000A5, 1'b0);
    op_then_check("lh_12",    1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEA5, 1'b0);
    op_then_check("lhu_10",   1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    op_then_check("lb_11",    1'b0, F3_B,  32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);

    // Faults
    op_then_check("lw_mis",   1'b0, F3_W,  32'h11, 32'h0, 32'h0, 1'b1);
    op_then_check("sh_mis",   1'b1, F3_H,  32'h13, 32'h00001234, 32'h0, 1'b1);
    op_then_check("lw_unchg", 1'b0, F3_W,  32'h10, 32'h0, 32'hDEA5BEEF, 1'b0);
    op_then_check("lw_oor",   1'b0, F3_W,  BASE + NBYTES, 32'h0, 32'h0, 1'b1);
    op_then_check("lw_high",  1'b0, F3_W,  32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
    op_then_check("st_f3_3",  1'b1, 3'd3,  32'h20, 32'hCAFEF00D, 32'h0, 1'b1);
    op_then_check("sbu_bad",  1'b1, F3_BU, 32'h20, 32'hCAFEF00D, 32'h0, 1'b1);
    op_then_check("ld_f3_6",  1'b0, 3'd6,  32'h10, 32'h0, 32'h0, 1'b1);
    op_then_check("sb_last",  1'b1, F3_B,  BASE + NBYTES - 1, 32'h00000081, 32'h0, 1'b0);
    op_then_check("lb_last",  1'b0, F3_B,  BASE + NBYTES - 1, 32'h0, 32'hFFFFFF81, 1'b0);

    // Back-pressure: 4 loads with the consumer stalled for 3 cycles
    bp_f3[0] = F3_W;  bp_a[0] = 32'h10;
    bp_f3[1] = F3_B;  bp_a[1] = 32'h12;
    bp_f3[2] = F3_HU; bp_a[2] = 32'h10;
    bp_f3[3] = F3_BU; bp_a[3] = BASE + NBYTES - 1;
    step(1'b1, 1'b0, bp_f3[0], bp_a[0], 32'd0, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, bp_f3[1], bp_a[1], 32'd0, 1'b0, acc);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_stable", s_rdata, 32'hDEA5BEEF);
    end
    for (int i = 1; i < 4; i++) issue(1'b0, bp_f3[i], bp_a[i], 32'd0, tries);
    drain();
    step(1'b0, 1'b0, F3_W, 32'd0, 32'd0, 1'b1, acc);

    // Full throughput: alternating SW/LW to distinct addresses
    for (int i = 0; i < 4; i++) begin
      a  = 32'h40 + 32'(8 * i);
      wd = $urandom;
      issue(1'b1, F3_W, a, wd, tries);
      chk("tp_sw_one_cycle", 32'(tries), 32'd1);
      issue(1'b0, F3_W, a, 32'd0, tries);
      chk("tp_lw_one_cycle", 32'(tries), 32'd1);
    end
    drain();

    // Reset while a response is pending; a store during reset is dropped
    step(1'b1, 1'b0, F3_W, 32'h10, 32'd0, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_err", 32'(rsp_err), 32'd0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h10; req_wdata = 32'h12345678; rsp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    op_then_check("post_rst_lw", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEA5BEEF, 1'b0);

    // Randomized: fill memory, then random traffic with random back-pressure
    for (int w = 0; w < DEPTH; w++) issue(1'b1, F3_W, BASE + 32'(4 * w), $urandom, tries);
    drain();
    for (int k = 0; k < 400; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, NBYTES + 15));
      n  = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), f3, BASE + a,
           $urandom, 1'($urandom_range(0, 3) != 0), acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
